// File: rtl/bpsk_ook_modulator.sv
// bpsk_ook_modulator: byte-serial BPSK/OOK keying of a 9-bit DDS carrier.
// Bytes are accepted on a valid/ready handshake and sent MSB first, with each
// bit held for SPB carrier samples. The output is registered, so latency is 1 cycle.
// Note: rst is active-low even though it carries no _n suffix.
module bpsk_ook_modulator #(
    parameter int SPB = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic signed [8:0] carrier,
    input  logic              mode,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic signed [8:0] mod_out,
    output logic              bit_strobe,
    output logic              busy
);

    localparam int             CW        = (SPB > 1) ? $clog2(SPB) : 1;
    localparam logic [CW-1:0]  SAMP_LAST = CW'(SPB - 1);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [7:0]        shreg;
    logic              mode_q;
    logic [CW-1:0]     samp_cnt;
    logic [2:0]        bit_cnt;
    logic              last;
    logic              accept;
    logic              cur_bit;
    logic signed [8:0] neg_carrier;
    logic signed [8:0] mod_nxt;

    // The final sample of bit 0 is the only SEND cycle that can take a new byte.
    // Taking it there gives back-to-back bytes with no gap sample.
    assign last     = (state == SEND) && (bit_cnt == 3'd0) && (samp_cnt == SAMP_LAST);
    assign in_ready = (state == IDLE) || last;
    assign accept   = in_valid && in_ready;
    assign busy     = (state == SEND);
    assign cur_bit  = shreg[7];

    // -(-256) does not fit in 9 bits, so it saturates to +255.
    assign neg_carrier = (carrier == -9'sd256) ? 9'sd255 : -carrier;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state: an accept always (re)enters SEND; the last sample without an accept drops to IDLE.
    always_comb begin
        state_nxt = state;
        if (accept)     state_nxt = SEND;
        else if (last)  state_nxt = IDLE;
    end

    // Byte shift register and the sample/bit counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg    <= 8'h00;
            mode_q   <= 1'b0;
            samp_cnt <= '0;
            bit_cnt  <= 3'd0;
        end else if (accept) begin
            shreg    <= in_data;
            mode_q   <= mode;
            samp_cnt <= '0;
            bit_cnt  <= 3'd7;
        end else if (state == SEND) begin
            if (last) begin
                shreg    <= 8'h00;
                samp_cnt <= '0;
                bit_cnt  <= 3'd0;
            end else if (samp_cnt == SAMP_LAST) begin
                samp_cnt <= '0;
                shreg    <= {shreg[6:0], 1'b0};
                bit_cnt  <= bit_cnt - 3'd1;
            end else begin
                samp_cnt <= samp_cnt + 1'b1;
            end
        end
    end

    // Keying: a 1 passes the carrier; a 0 inverts it (BPSK) or blanks it (OOK).
    always_comb begin
        mod_nxt = 9'sd0;
        if (state == SEND) begin
            if (cur_bit)      mod_nxt = carrier;
            else if (!mode_q) mod_nxt = neg_carrier;
        end
    end

    // Registered outputs. The strobe marks the first sample of each bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mod_out    <= 9'sd0;
            bit_strobe <= 1'b0;
        end else begin
            mod_out    <= mod_nxt;
            bit_strobe <= (state == SEND) && (samp_cnt == '0);
        end
    end

endmodule

// File: tb/tb_bpsk_ook_modulator.sv
// Testbench for bpsk_ook_modulator. Four instances (SPB = 1, 3, 4, 16) share the
// same stimulus. A per-instance transaction model predicts every output cycle:
// each instance tracks its current byte and its sample position within that byte.
module tb_bpsk_ook_modulator;

    localparam int NI = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic signed [8:0] carrier = 9'sd0;
    logic              mode = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;

    logic              in_ready_a   [NI];
    logic signed [8:0] mod_out_a    [NI];
    logic              bit_strobe_a [NI];
    logic              busy_a       [NI];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NI; gi++) begin : g_dut
            localparam int SP = (gi == 0) ? 1 : (gi == 1) ? 3 : (gi == 2) ? 4 : 16;
            bpsk_ook_modulator #(.SPB(SP)) u_dut (
                .clk        (clk),
                .rst        (rst),
                .carrier    (carrier),
                .mode       (mode),
                .in_data    (in_data),
                .in_valid   (in_valid),
                .in_ready   (in_ready_a[gi]),
                .mod_out    (mod_out_a[gi]),
                .bit_strobe (bit_strobe_a[gi]),
                .busy       (busy_a[gi])
            );
        end
    endgenerate

    // Per-instance model state.
    bit         m_busy [NI];
    int         m_pos  [NI];
    logic [7:0] m_byte [NI];
    bit         m_mode [NI];
    int         e_out  [NI];
    bit         e_strb [NI];

    int n_chk  = 0;
    int n_pass = 0;
    int ph     = 0;

    function automatic int spb_of(int i);
        case (i)
            0:       return 1;
            1:       return 3;
            2:       return 4;
            default: return 16;
        endcase
    endfunction

    function automatic int sat_neg(int c);
        return (-c > 255) ? 255 : -c;
    endfunction

    task automatic chk(string tag, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_busy[i] = 1'b0;
            m_pos[i]  = 0;
            m_byte[i] = 8'h00;
            m_mode[i] = 1'b0;
            e_out[i]  = 0;
            e_strb[i] = 1'b0;
        end
    endtask

    task automatic check_all(string ph_name);
        for (int i = 0; i < NI; i++) begin
            int  sp  = spb_of(i);
            bit  rdy = !m_busy[i] || (m_pos[i] == 8 * sp - 1);
            string t = $sformatf("%s spb=%0d", ph_name, sp);
            chk({t, " mod_out"},    int'(mod_out_a[i]),    e_out[i]);
            chk({t, " bit_strobe"}, int'(bit_strobe_a[i]), int'(e_strb[i]));
            chk({t, " busy"},       int'(busy_a[i]),       int'(m_busy[i]));
            chk({t, " in_ready"},   int'(in_ready_a[i]),   int'(rdy));
        end
    endtask

    // Advance one clock. The model consumes the inputs present at the edge,
    // and all outputs are checked 1 time unit after the edge.
    task automatic step(string ph_name);
        int c = int'(carrier);
        if (!rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < NI; i++) begin
                int sp  = spb_of(i);
                bit rdy = !m_busy[i] || (m_pos[i] == 8 * sp - 1);
                if (m_busy[i]) begin
                    bit b = m_byte[i][7 - m_pos[i] / sp];
                    e_out[i]  = b ? c : (m_mode[i] ? 0 : sat_neg(c));
                    e_strb[i] = (m_pos[i] % sp) == 0;
                end else begin
                    e_out[i]  = 0;
                    e_strb[i] = 1'b0;
                end
                if (in_valid && rdy) begin
                    m_busy[i] = 1'b1;
                    m_pos[i]  = 0;
                    m_byte[i] = in_data;
                    m_mode[i] = mode;
                end else if (m_busy[i]) begin
                    if (m_pos[i] == 8 * sp - 1) begin
                        m_busy[i] = 1'b0;
                        m_pos[i]  = 0;
                    end else begin
                        m_pos[i]++;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        check_all(ph_name);
    endtask

    // Toggle mode randomly during the run; a live carrier follows a sine.
    task automatic run(string ph_name, int n, bit live);
        for (int k = 0; k < n; k++) begin
            mode = 1'($urandom);
            if (live) begin
                ph += 5;
                carrier = 9'($rtoi(255.0 * $sin(2.0 * 3.14159265 * ph / 64.0)));
            end
            step(ph_name);
        end
    endtask

    task automatic send(string ph_name, logic [7:0] d, logic m);
        in_valid = 1'b1;
        in_data  = d;
        mode     = m;
        step(ph_name);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // Asynchronous reset mid-operation: outputs must clear before any edge.
    task automatic async_reset(string ph_name);
        rst = 1'b0;
        #1;
        model_reset();
        check_all({ph_name, " async"});
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            carrier  = 9'($urandom);
            step({ph_name, " held"});
        end
        in_valid = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        rst = 1'b0;
        #1;
        check_all("reset");
        in_valid = 1'b1;
        step("reset_held");
        step("reset_held");
        rst = 1'b1;
        in_valid = 1'b0;
        run("idle", 4, 1'b0);

        // BPSK 0xA5 with a constant +100 carrier.
        carrier = 9'sd100;
        send("bpsk_a5", 8'hA5, 1'b0);
        run("bpsk_a5", 140, 1'b0);

        // OOK 0x81 with a -37 carrier; mode toggles mid-byte.
        carrier = -9'sd37;
        send("ook_81", 8'h81, 1'b1);
        run("ook_81", 140, 1'b0);

        // Saturation on negation, then an ordinary full-scale value.
        carrier = -9'sd256;
        send("sat_neg256", 8'h00, 1'b0);
        run("sat_neg256", 140, 1'b0);
        carrier = 9'sd255;
        send("sat_pos255", 8'h00, 1'b0);
        run("sat_pos255", 140, 1'b0);

        // Back-to-back: valid held high, 0xF0 followed by 0x0F.
        carrier = 9'sd77;
        in_valid = 1'b1;
        in_data  = 8'hF0;
        mode     = 1'b0;
        step("b2b");
        in_data = 8'h0F;
        for (int k = 0; k < 130; k++) step("b2b");
        in_valid = 1'b0;
        run("b2b_tail", 140, 1'b0);

        // Live sine carrier with 0x55 in BPSK.
        send("live_55", 8'h55, 1'b0);
        run("live_55", 140, 1'b1);

        // Randomized traffic, with occasional asynchronous resets.
        for (int k = 0; k < 4000; k++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom);
            mode     = 1'($urandom);
            carrier  = ($urandom_range(0, 31) == 0) ? -9'sd256 : 9'($urandom);
            if ($urandom_range(0, 499) == 0) async_reset("rand_rst");
            else step("random");
        end
        in_valid = 1'b0;
        run("drain", 140, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bpsk_ook_modulator.md
# bpsk_ook_modulator

Byte-serial digital modulator directly downstream of the DDS data path. Consumes the DDS 9-bit two's-complement sine sample every cycle as the carrier and keys it with data bits. Bytes arrive on a valid/ready handshake and are sent MSB first, each bit held for `SPB` carrier samples, in BPSK or OOK mode. The registered 9-bit modulated output feeds the DAC or channel stage.

## Interface
- `SPB`, 16, samples per bit; integer, 1..65535; counter width = clog2(SPB), minimum 1.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `carrier`  in  9  signed DDS sample, new value every cycle.
- `mode`  in  1  0 = BPSK, 1 = OOK; sampled only at byte accept.
- `in_data`  in  8  byte to transmit.
- `in_valid`  in  1  `in_data`/`mode` valid.
- `in_ready`  out  1  block accepts a byte this cycle.
- `mod_out`  out  9  signed modulated sample, registered.
- `bit_strobe`  out  1  registered; high on the first `mod_out` sample of each bit.
- `busy`  out  1  high while a byte is being sent.

## Operation
- States: IDLE, SEND.
- Registers: `shreg[7:0]`, `mode_q`, `samp_cnt` (0..SPB-1), `bit_cnt` (7..0), `mod_out`, `bit_strobe`.
- `last` = SEND && `bit_cnt`==0 && `samp_cnt`==SPB-1.
- `in_ready` = IDLE || `last` (combinational from state/counters).
- Accept = `in_valid` && `in_ready`: `shreg`<=`in_data`, `mode_q`<=`mode`, `bit_cnt`<=7, `samp_cnt`<=0, state<=SEND.
- SEND, not accepting: `samp_cnt` increments; at SPB-1 it wraps to 0, `shreg` shifts left by 1, `bit_cnt` decrements.
- At `last` with no accept: state<=IDLE, counters cleared.
- At `last` with accept: new byte loads and SEND continues with no gap sample (back-to-back).
- Current bit `b` = `shreg[7]`.
- `mod_out` next value:
  - IDLE: 0.
  - SEND, BPSK: `b`=1 gives `carrier`; `b`=0 gives -`carrier`.
  - SEND, OOK: `b`=1 gives `carrier`; `b`=0 gives 0.
- Negation is 9-bit with saturation: -(-256) = +255. All other values negate exactly.
- `bit_strobe` next value = SEND && `samp_cnt`==0.
- `busy` = (state==SEND), combinational from state.
- `mode` changes mid-byte are ignored; only `mode_q` is used.
- `in_valid` held low in IDLE: block stays idle and `mod_out` stays 0.
- `in_data` is not required to be stable when `in_ready`=0.

## Timing
- Reset (`rst`=0, asynchronous) sets:
  - state IDLE; `shreg`, `mode_q`, counters = 0.
  - `mod_out`=0, `bit_strobe`=0, `busy`=0, `in_ready`=1.
- Handshakes are ignored while `rst`=0. Assertion mid-byte aborts the byte and the partial byte is lost.
- Accept at edge E: `busy`=1 from E. The sample for `carrier` at cycle E+k (k=0..8*SPB-1) appears on `mod_out` after edge E+k+1. Latency is 1 cycle.
- One byte occupies exactly 8*SPB SEND cycles.
- Without a back-to-back accept, `mod_out` returns to 0 one cycle after `busy` falls.
- `bit_strobe` is high on `mod_out` samples 0, SPB, 2*SPB, ... of each byte. It is asserted exactly 8 times per byte.
- SPB=1: every SEND cycle is a bit start. `in_ready` is high on the bit-0 cycle only.

## Test plan
- Reset: assert `rst`=0 mid-operation with random inputs -> `mod_out`=0, `busy`=0, `bit_strobe`=0, `in_ready`=1 immediately. After release, no output until a new accept.
- BPSK, SPB=4, `carrier`=+100 constant, byte 0xA5 -> `mod_out` is 4 samples each of +100,-100,+100,-100,-100,+100,-100,+100. `bit_strobe` is high at samples 0,4,...,28. Then 0.
- OOK, SPB=2, `carrier`=-37, byte 0x81 -> -37,-37, then 12 samples of 0, then -37,-37. `mode` toggled mid-byte has no effect.
- Saturation: BPSK, byte 0x00, `carrier`=-256 -> `mod_out`=+255. `carrier`=+255 -> -255.
- Back-to-back: `in_valid` held high with bytes 0xF0 then 0x0F, SPB=3 -> 48 contiguous SEND samples with no zero gap. `in_ready` is high only on the last cycle of the first byte.
- Live carrier: connect the DDS output, SPB=16, byte 0x55, BPSK -> each `mod_out` equals ±`carrier` of the previous cycle. A golden model compares every sample.
